// File: rtl/subleq_pkg.sv
// Shared definitions for the SUBLEQ machine.
// WORD_SIZE: width of every data word and address.
package subleq_pkg;
  localparam int WORD_SIZE = 16;
endpackage

// File: rtl/subleq_ram.sv
// Word RAM answering a 4-phase req/ack handshake with a fixed wait.
// Ports: clk, rst (async high), mem_req/mem_load/mem_store/mem_addr/mem_in
// from the requester; mem_out (read data) and mem_ack back to it.
module subleq_ram
  import subleq_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_req,
  input  logic                 mem_load,
  input  logic                 mem_store,
  input  logic [WORD_SIZE-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0] mem_in,
  output logic [WORD_SIZE-1:0] mem_out,
  output logic                 mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    RELEASE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [3:0]           cnt;
  logic [WORD_SIZE-1:0] cap_addr;
  logic [WORD_SIZE-1:0] cap_in;
  logic                 cap_load;
  logic                 cap_store;

  logic [WORD_SIZE-1:0] mem [2**ADDR_BITS];

  logic                 fire;
  logic                 in_range;
  logic                 do_write;
  logic [ADDR_BITS-1:0] idx;

  // Access happens on the edge that leaves WAIT.
  assign fire     = (state == WAIT) && (cnt == 4'd0);
  // Any address bit above the storage depth makes the access a no-op.
  assign in_range = (cap_addr >> ADDR_BITS) == '0;
  assign idx      = cap_addr[ADDR_BITS-1:0];
  assign do_write = fire && cap_store && in_range;
  assign mem_ack  = (state == ACK);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (mem_req) state_nx = WAIT;
      WAIT:    if (cnt == 4'd0) state_nx = ACK;
      ACK:     if (!mem_req) state_nx = RELEASE;
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_addr  <= '0;
      cap_in    <= '0;
      cap_load  <= 1'b0;
      cap_store <= 1'b0;
      mem_out   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && mem_req) begin
        cap_addr  <= mem_addr;
        cap_in    <= mem_in;
        cap_load  <= mem_load;
        cap_store <= mem_store;
        cnt       <= 4'(LATENCY);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Load+store echoes the written word; a pure store leaves
      // mem_out holding the last read.
      if (fire && cap_load) begin
        if (!in_range)
          mem_out <= '0;
        else if (cap_store)
          mem_out <= cap_in;
        else
          mem_out <= mem[idx];
      end
    end
  end

  // Storage is never reset; the write enable is qualified by the
  // reset state so an aborted WAIT cannot commit.
  always_ff @(posedge clk) begin
    if (do_write)
      mem[idx] <= cap_in;
  end

endmodule

// File: tb/tb_subleq_ram.sv
// Directed bench for subleq_ram: two instances, LATENCY 2 and 0.
// Checks timing of mem_ack, read data, range and reset behaviour.
module tb_subleq_ram;
  import subleq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic                 req  [2];
  logic                 ld   [2];
  logic                 st   [2];
  logic [WORD_SIZE-1:0] addr [2];
  logic [WORD_SIZE-1:0] din  [2];
  logic [WORD_SIZE-1:0] dout [2];
  logic                 ack  [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  subleq_ram #(.ADDR_BITS(10), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst),
    .mem_req(req[0]), .mem_load(ld[0]), .mem_store(st[0]),
    .mem_addr(addr[0]), .mem_in(din[0]),
    .mem_out(dout[0]), .mem_ack(ack[0])
  );

  subleq_ram #(.ADDR_BITS(10), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst),
    .mem_req(req[1]), .mem_load(ld[1]), .mem_store(st[1]),
    .mem_addr(addr[1]), .mem_in(din[1]),
    .mem_out(dout[1]), .mem_ack(ack[1])
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Edges counted from raising req (at a negedge) until ack is seen.
  // From IDLE the first edge samples, so ack lands on edge LAT+2;
  // raised during ACK->RELEASE it lands one edge later.
  task automatic access(string tag, int d, bit l, bit s,
                        logic [15:0] a, logic [15:0] w,
                        bit b2b, logic [15:0] exp_out);
    int n;
    n = 0;
    if (!b2b) @(negedge clk);
    @(negedge clk);
    req[d] = 1'b1; ld[d] = l; st[d] = s;
    addr[d] = a; din[d] = w;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack[d] && n < 40);
    check({tag, "_lat"}, n, lat_of(d) + (b2b ? 3 : 2));
    @(negedge clk);
    check({tag, "_out"}, dout[d], exp_out);
    req[d] = 1'b0; ld[d] = 1'b0; st[d] = 1'b0;
    addr[d] = 16'($urandom); din[d] = 16'($urandom);
    @(posedge clk); #1;
    check({tag, "_rel"}, ack[d], 1'b0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; ld[i] = 1'b0; st[i] = 1'b0;
      addr[i] = '0; din[i] = '0;
    end
    #12;
    check("rst_ack0", ack[0], 1'b0);
    check("rst_out0", dout[0], 16'h0);
    check("rst_ack1", ack[1], 1'b0);
    check("rst_out1", dout[1], 16'h0);
    @(negedge clk); rst = 1'b0;

    access("st5",    0, 0, 1, 16'd5,    16'h1234, 0, 16'h0000);
    access("ld5",    0, 1, 0, 16'd5,    16'h0000, 0, 16'h1234);
    access("both7",  0, 1, 1, 16'd7,    16'hBEEF, 0, 16'hBEEF);
    access("ld7",    0, 1, 0, 16'd7,    16'h0000, 0, 16'hBEEF);
    access("st0",    0, 0, 1, 16'd0,    16'h0F0F, 0, 16'hBEEF);
    access("ld_oor", 0, 1, 0, 16'h0400, 16'h0000, 0, 16'h0000);
    access("st_oor", 0, 0, 1, 16'h0400, 16'h7777, 0, 16'h0000);
    access("ld0",    0, 1, 0, 16'd0,    16'h0000, 0, 16'h0F0F);
    access("none7",  0, 0, 0, 16'd7,    16'h1111, 0, 16'h0F0F);
    access("st10",   0, 0, 1, 16'd10,   16'h0000, 0, 16'h0F0F);

    // Change address and data right after the capture edge.
    @(negedge clk); @(negedge clk);
    req[0] = 1'b1; st[0] = 1'b1; ld[0] = 1'b0;
    addr[0] = 16'd9; din[0] = 16'h4321;
    @(posedge clk); #1;
    @(negedge clk);
    addr[0] = 16'd10; din[0] = 16'h9999; st[0] = 1'b0; ld[0] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack[0] && n < 40);
    check("cap_lat", n, 3);
    @(negedge clk); req[0] = 1'b0; ld[0] = 1'b0;
    access("ld9",  0, 1, 0, 16'd9,  16'h0000, 0, 16'h4321);
    access("ld10", 0, 1, 0, 16'd10, 16'h0000, 0, 16'h0000);

    // req dropped while waiting: access completes, one ACK cycle.
    @(negedge clk); @(negedge clk);
    req[0] = 1'b1; ld[0] = 1'b1; addr[0] = 16'd5;
    @(posedge clk); #1;
    @(negedge clk); req[0] = 1'b0; ld[0] = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack[0] && n < 40);
    check("viol_lat", n, 3);
    @(negedge clk);
    check("viol_out", dout[0], 16'h1234);
    @(posedge clk); #1;
    check("viol_rel", ack[0], 1'b0);

    // LATENCY 0 instance, including a back-to-back request.
    access("l0_st0", 1, 0, 1, 16'd0, 16'h00FF, 0, 16'h0000);
    access("l0_ld0", 1, 1, 0, 16'd0, 16'h0000, 1, 16'h00FF);
    access("l0_ld0b", 1, 1, 0, 16'd0, 16'h0000, 0, 16'h00FF);

    // Reset during WAIT of a store must not write.
    access("st3",  0, 0, 1, 16'd3, 16'h5555, 0, 16'h1234);
    access("ld3",  0, 1, 0, 16'd3, 16'h0000, 0, 16'h5555);
    @(negedge clk); @(negedge clk);
    req[0] = 1'b1; st[0] = 1'b1; addr[0] = 16'd3; din[0] = 16'hAAAA;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1; #1;
    check("rstw_ack", ack[0], 1'b0);
    check("rstw_out", dout[0], 16'h0000);
    @(negedge clk);
    rst = 1'b0; req[0] = 1'b0; st[0] = 1'b0;
    access("ld3r", 0, 1, 0, 16'd3, 16'h0000, 0, 16'h5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/subleq_ram.md
SUBLEQ_RAM -- requirements
Module: subleq_ram

Interface
REQ-001 The block SHALL take WORD_SIZE from the shared defines header; every data and address port below is WORD_SIZE bits wide.
REQ-002 Parameter ADDR_BITS, default 10, SHALL set the storage depth to 2**ADDR_BITS words (ADDR_BITS <= WORD_SIZE).
REQ-003 Parameter LATENCY, default 2, SHALL set the extra wait cycles before acknowledge (legal range 0..15).
REQ-004 Port list, one per line (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_req  in  1  request, 4-phase handshake
- mem_load  in  1  read access
- mem_store  in  1  write access
- mem_addr  in  WORD_SIZE  word address
- mem_in  in  WORD_SIZE  write data
- mem_out  out  WORD_SIZE  read data
- mem_ack  out  1  acknowledge

Function
REQ-005 The block SHALL be the memory-side responder of the req/ack protocol: the requester raises mem_req with mem_load/mem_store/mem_addr/mem_in stable, holds it until mem_ack is high, then drops it; the block drops mem_ack after mem_req falls.
REQ-006 The FSM SHALL have states IDLE, WAIT, ACK, RELEASE, encoded in 2 bits.
REQ-007 IDLE: mem_req high at an edge -> capture mem_addr, mem_in, mem_load, mem_store into registers; load LATENCY into the down-counter; go to WAIT.
REQ-008 WAIT: counter nonzero -> decrement and stay; counter zero -> perform the access, go to ACK.
REQ-009 Transfer: mem_ack SHALL rise exactly LATENCY+1 edges after the edge that sampled mem_req in IDLE.
REQ-010 ACK: mem_ack high, mem_out holds read data; mem_req low at an edge -> go to RELEASE.
REQ-011 RELEASE: mem_ack low for exactly one cycle; then IDLE. A new request is sampled no earlier than the edge after RELEASE.
REQ-012 In IDLE and WAIT, mem_ack SHALL be 0.
REQ-013 Request signals changing after the capture edge SHALL have no effect on the transfer in progress.
REQ-014 Store: the write to word captured_addr[ADDR_BITS-1:0] SHALL commit on the WAIT->ACK edge and nothing else is written.
REQ-015 Load: mem_out SHALL present the word at the captured address from the ACK entry edge until the next access completes.
REQ-016 mem_load and mem_store both high SHALL act as store; mem_out then shows the newly written value.
REQ-017 mem_load and mem_store both low SHALL be acknowledged normally, with no write and mem_out unchanged.
REQ-018 Address with any bit at or above ADDR_BITS set (out of range) SHALL be acknowledged normally: a store writes nothing; a load returns 0.
REQ-019 mem_req falling while in WAIT is a protocol violation; the block SHALL still complete the access, then pass through ACK for one cycle and RELEASE.
REQ-020 Storage contents SHALL NOT be cleared by reset; unwritten contents are undefined.

Reset
REQ-021 rst high SHALL asynchronously force state IDLE, counter 0, mem_ack 0, mem_out 0, and captured registers 0.
REQ-022 rst during WAIT SHALL abort the pending store with no write; a store already committed in ACK is kept.
REQ-023 After rst falls, the first request SHALL be sampled at the first rising edge with rst low.

Verification
REQ-024 Scenarios:
- LATENCY=2: store addr 5, data 0x1234; then load addr 5 -> mem_ack rises 3 edges after request capture; mem_out=0x1234 while mem_ack high.
- LATENCY=0: load after a store of 0x00FF to addr 0 -> mem_ack high 1 edge after capture, mem_out=0x00FF; RELEASE holds mem_ack low for exactly 1 cycle.
- Load and store both high, addr 7, data 0xBEEF -> word 7 written; mem_out=0xBEEF.
- Load from address 2**ADDR_BITS -> acknowledged, mem_out=0; store to that address leaves word 0 unchanged.
- Reset asserted in WAIT of a store of 0xAAAA to addr 3, where addr 3 previously held 0x5555 -> mem_ack=0 immediately; a later load of addr 3 returns 0x5555.
- mem_addr and mem_in changed one cycle after capture -> the original captured address and data are used.
